// File: rtl/axi_mctp_write_master_if.sv
// AXI4 write-channel bundle (AW, W, B) between the MCTP write master and the
// interconnect.
//   master modport : drives AW*/W* and BREADY, samples AWREADY/WREADY/B*
//   slave  modport : the mirror image
interface axi_mctp_write_master_if #(
  parameter int DATA_W = 256,
  parameter int ADDR_W = 64,
  parameter int ID_W   = 7
);
  logic [63:0]         awuser;
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [15:0]         wuser;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output awuser, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wuser, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready
  );

  modport slave (
    input  awuser, awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wuser, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready
  );
endinterface

// File: rtl/axi_mctp_write_master.sv
// AXI4 write master carrying one MCTP-over-PCIe VDM packet per burst.
// Beat 0 carries the 128-bit header in WDATA[127:0] with payload in the upper
// lanes; later beats are pure payload. Waits for B with an optional timeout.
// Ports:
//   i_clk, i_reset_n          clock, async active-low reset
//   i_cmd_* / o_cmd_ready     command stream (header, addr, len, id)
//   i_pld_* / o_pld_ready     payload beat stream
//   o_busy, o_done*           status and one-cycle completion pulse with result
//   axi                       AXI4 AW/W/B master
module axi_mctp_write_master #(
  parameter int DATA_W       = 256,
  parameter int ADDR_W       = 64,
  parameter int ID_W         = 7,
  parameter int RESP_TIMEOUT = 1024
) (
  input  logic                   i_clk,
  input  logic                   i_reset_n,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [127:0]           i_cmd_header,
  input  logic [ADDR_W-1:0]      i_cmd_addr,
  input  logic [7:0]             i_cmd_len,
  input  logic [ID_W-1:0]        i_cmd_id,
  input  logic                   i_pld_valid,
  output logic                   o_pld_ready,
  input  logic [DATA_W-1:0]      i_pld_data,
  output logic                   o_busy,
  output logic                   o_done,
  output logic [1:0]             o_done_resp,
  output logic [1:0]             o_done_err,
  axi_mctp_write_master_if.master axi
);
  localparam logic [2:0]  AW_SIZE  = 3'($clog2(DATA_W/8));
  localparam logic [31:0] TMO_LAST = 32'(RESP_TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;
  state_t state_q, state_d;

  logic [127:0] hdr_q;
  logic [7:0]   len_q;
  logic [8:0]   beats_q;   // beats loaded into the W stage so far (0..len+1)
  logic [31:0]  tcnt_q;
  logic cmd_hs, aw_hs, w_hs, last_hs, pld_hs, b_hs, tmo, resp_end;

  assign cmd_hs   = i_cmd_valid & o_cmd_ready;
  assign aw_hs    = axi.awvalid & axi.awready;
  assign w_hs     = axi.wvalid & axi.wready;
  assign last_hs  = w_hs & axi.wlast;
  // W stage accepts a new beat when empty or draining this cycle
  assign o_pld_ready = (state_q == S_DATA) && (beats_q <= {1'b0, len_q}) &&
                       (!axi.wvalid || axi.wready);
  assign pld_hs   = i_pld_valid & o_pld_ready;
  assign b_hs     = axi.bvalid & axi.bready;
  // RESP cycles are counted from 0, so expiry is the RESP_TIMEOUT-th cycle
  assign tmo      = (RESP_TIMEOUT != 0) && (tcnt_q == TMO_LAST);
  assign resp_end = (state_q == S_RESP) && (b_hs || tmo);
  assign o_busy   = (state_q != S_IDLE);

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) state_q <= S_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (cmd_hs)   state_d = S_ADDR;
      S_ADDR:  if (aw_hs)    state_d = S_DATA;
      S_DATA:  if (last_hs)  state_d = S_RESP;
      S_RESP:  if (resp_end) state_d = S_IDLE;
      default:               state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_cmd_ready <= 1'b0;
      o_done      <= 1'b0;
      o_done_resp <= 2'b00;
      o_done_err  <= 2'b00;
      hdr_q       <= '0;
      len_q       <= '0;
      beats_q     <= '0;
      tcnt_q      <= '0;
      axi.awvalid <= 1'b0;
      axi.awaddr  <= '0;
      axi.awid    <= '0;
      axi.awlen   <= '0;
      axi.awsize  <= '0;
      axi.awburst <= '0;
      axi.awlock  <= 1'b0;
      axi.awcache <= '0;
      axi.awprot  <= '0;
      axi.awuser  <= '0;
      axi.wvalid  <= 1'b0;
      axi.wdata   <= '0;
      axi.wstrb   <= '0;
      axi.wlast   <= 1'b0;
      axi.wuser   <= '0;
      axi.bready  <= 1'b0;
    end else begin
      // blocked during the o_done cycle so a new command starts one cycle later
      o_cmd_ready <= (state_d == S_IDLE) && !resp_end;
      o_done      <= resp_end;

      if (cmd_hs) begin
        hdr_q       <= i_cmd_header;
        len_q       <= i_cmd_len;
        axi.awvalid <= 1'b1;
        axi.awaddr  <= i_cmd_addr;
        axi.awid    <= i_cmd_id;
        axi.awlen   <= i_cmd_len;
        axi.awsize  <= AW_SIZE;
        axi.awburst <= 2'b01;
        axi.awlock  <= 1'b0;
        axi.awcache <= '0;
        axi.awprot  <= '0;
        axi.awuser  <= '0;
      end else if (aw_hs) begin
        axi.awvalid <= 1'b0;
      end

      if (aw_hs)       beats_q <= '0;
      else if (pld_hs) beats_q <= beats_q + 9'd1;

      // a new beat wins over draining the old one
      if (pld_hs) begin
        axi.wdata  <= (beats_q == 9'd0) ? {i_pld_data[DATA_W-1:128], hdr_q} : i_pld_data;
        axi.wvalid <= 1'b1;
        axi.wstrb  <= '1;
        axi.wuser  <= '0;
        axi.wlast  <= (beats_q == {1'b0, len_q});
      end else if (w_hs) begin
        axi.wvalid <= 1'b0;
        axi.wlast  <= 1'b0;
      end

      if (last_hs)       axi.bready <= 1'b1;
      else if (resp_end) axi.bready <= 1'b0;

      if (last_hs)                 tcnt_q <= '0;
      else if (state_q == S_RESP)  tcnt_q <= tcnt_q + 32'd1;

      // BVALID on the expiry cycle counts as a normal completion
      if (resp_end) begin
        if (b_hs) begin
          o_done_resp <= axi.bresp;
          o_done_err  <= {axi.bid != axi.awid, 1'b0};
        end else begin
          o_done_resp <= 2'b10;
          o_done_err  <= 2'b01;
        end
      end
    end
  end
endmodule

// File: tb/tb_axi_mctp_write_master.sv
module tb_axi_mctp_write_master;
  localparam int DW = 256, AW = 64, IW = 7, TO = 16;

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          cmd_valid, cmd_ready;
  logic [127:0]  cmd_hdr;
  logic [AW-1:0] cmd_addr;
  logic [7:0]    cmd_len;
  logic [IW-1:0] cmd_id;
  logic          pld_valid, pld_ready;
  logic [DW-1:0] pld_data;
  logic          busy, done;
  logic [1:0]    done_resp, done_err;

  axi_mctp_write_master_if #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus_if ();

  axi_mctp_write_master #(.DATA_W(DW), .ADDR_W(AW), .ID_W(IW), .RESP_TIMEOUT(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready), .i_cmd_header(cmd_hdr),
    .i_cmd_addr(cmd_addr), .i_cmd_len(cmd_len), .i_cmd_id(cmd_id),
    .i_pld_valid(pld_valid), .o_pld_ready(pld_ready), .i_pld_data(pld_data),
    .o_busy(busy), .o_done(done), .o_done_resp(done_resp), .o_done_err(done_err),
    .axi(bus_if)
  );

  typedef struct {
    logic [127:0]  hdr;
    logic [AW-1:0] addr;
    logic [7:0]    len;
    logic [IW-1:0] id;
    int            aw_stall;
    bit            w_toggle;
    bit            gap;
    int            bdel;     // cycles after the WLAST handshake before BVALID
    logic [IW-1:0] bid;
    logic [1:0]    bresp;
  } cmd_t;

  cmd_t          cmd_q[$];
  cmd_t          cur;
  logic [DW-1:0] pld_q[$];
  logic [DW-1:0] exp_w[$];

  int total = 0, bad = 0;
  int cyc = 0, dut_done_cnt = 0;
  bit in_flight, done_pend, aw_done, b_armed;
  int exp_done_cyc, t_last, aw_cnt, k_cmd, beat_idx, beats_seen, wlast_cnt, aw_hi, done_delay;
  logic [127:0] w0_lo;
  logic [1:0]   exp_resp, exp_err, p_resp, p_err;
  bit            p_awv, p_awr, p_wv, p_wr;
  logic [AW-1:0] p_awaddr;
  logic [7:0]    p_awlen;
  logic [IW-1:0] p_awid;
  logic [DW-1:0] p_wdata;

  localparam logic [127:0] HDR1 = 128'hC820_0000_1122_3344_5566_7788_0000_0020;

  task automatic chk(string name, logic [255:0] act, logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] pld_word(int k, int b);
    logic [DW-1:0] d;
    for (int i = 0; i < DW/32; i++) d[i*32 +: 32] = {8'(k), 8'(b), 8'(i), 8'h5A};
    return d;
  endfunction

  function automatic cmd_t mk(logic [127:0] h, logic [AW-1:0] a, logic [7:0] l, logic [IW-1:0] id,
                              int st, bit tg, bit gp, int bd, logic [IW-1:0] bid, logic [1:0] br);
    cmd_t c;
    c.hdr = h; c.addr = a; c.len = l; c.id = id; c.aw_stall = st; c.w_toggle = tg;
    c.gap = gp; c.bdel = bd; c.bid = bid; c.bresp = br;
    return c;
  endfunction

  task automatic clear_model();
    pld_q.delete(); exp_w.delete();
    in_flight = 0; done_pend = 0; aw_done = 0; b_armed = 0; aw_cnt = 0;
    exp_resp = 2'b00; exp_err = 2'b00;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
  endtask

  // Model + compare, evaluated once per cycle with inputs and outputs settled
  task automatic monitor();
    bit exp_done;
    logic [DW-1:0] d;
    if (!rst_n) begin
      chk("rst_aw", {bus_if.awvalid, bus_if.awaddr, bus_if.awid, bus_if.awlen, bus_if.awsize,
                     bus_if.awburst, bus_if.awlock, bus_if.awcache, bus_if.awprot, bus_if.awuser}, 0);
      chk("rst_wdata", bus_if.wdata, 0);
      chk("rst_w", {bus_if.wvalid, bus_if.wlast, bus_if.wstrb, bus_if.wuser, bus_if.bready}, 0);
      chk("rst_o", {cmd_ready, pld_ready, busy, done, done_resp, done_err}, 0);
      clear_model();
      return;
    end
    chk("cmd_ready", cmd_ready, !in_flight);
    chk("busy", busy, in_flight && !(done_pend && cyc >= exp_done_cyc));
    exp_done = done_pend && (cyc == exp_done_cyc);
    chk("done", done, exp_done);
    if (done) dut_done_cnt++;
    if (exp_done) begin
      exp_resp = p_resp; exp_err = p_err;
      in_flight = 0; done_pend = 0; b_armed = 0; done_delay = cyc - t_last;
    end
    chk("done_resp", done_resp, exp_resp);
    chk("done_err", done_err, exp_err);

    if (p_awv && !p_awr)
      chk("aw_hold", {bus_if.awvalid, bus_if.awaddr, bus_if.awlen, bus_if.awid},
                     {1'b1, p_awaddr, p_awlen, p_awid});
    if (bus_if.awvalid) aw_hi++;
    if (bus_if.awvalid && bus_if.awready) begin
      chk("aw_fields", {bus_if.awaddr, bus_if.awlen, bus_if.awid}, {cur.addr, cur.len, cur.id});
      chk("aw_attr", {bus_if.awsize, bus_if.awburst, bus_if.awlock, bus_if.awcache, bus_if.awprot,
                      bus_if.awuser}, {3'($clog2(DW/8)), 2'b01, 1'b0, 4'd0, 3'd0, 64'd0});
      aw_done = 1; aw_cnt = 0;
    end else if (bus_if.awvalid) aw_cnt++;

    chk("w_order", bus_if.wvalid && !aw_done, 0);
    if (p_wv && !p_wr) begin
      chk("w_hold_v", bus_if.wvalid, 1);
      chk("w_hold_d", bus_if.wdata, p_wdata);
    end
    if (bus_if.wvalid && bus_if.wready) begin
      chk("w_extra", exp_w.size() > 0, 1);
      if (exp_w.size() > 0) begin
        chk("wdata", bus_if.wdata, exp_w[0]);
        void'(exp_w.pop_front());
        chk("wlast", bus_if.wlast, beat_idx == int'(cur.len));
        chk("wstrb_user", {bus_if.wstrb, bus_if.wuser}, {32'hFFFF_FFFF, 16'h0});
        if (beat_idx == 0) w0_lo = bus_if.wdata[127:0];
        if (bus_if.wlast) wlast_cnt++;
        beats_seen++;
        if (beat_idx == int'(cur.len)) begin
          // response outcome follows from when the slave raises BVALID
          t_last = cyc; b_armed = 1; done_pend = 1;
          if (cur.bdel >= 1 && cur.bdel <= TO) begin
            exp_done_cyc = cyc + cur.bdel + 1;
            p_resp = cur.bresp; p_err = {cur.bid != cur.id, 1'b0};
          end else begin
            exp_done_cyc = cyc + TO + 1;
            p_resp = 2'b10; p_err = 2'b01;
          end
        end
        beat_idx++;
      end
    end

    if (pld_valid && pld_ready) void'(pld_q.pop_front());
    if (cmd_valid && cmd_ready) begin
      cur = cmd_q.pop_front();
      for (int b = 0; b <= int'(cur.len); b++) begin
        d = pld_word(k_cmd, b);
        pld_q.push_back(d);
        if (b == 0) d[127:0] = cur.hdr;
        exp_w.push_back(d);
      end
      in_flight = 1; aw_done = 0; aw_cnt = 0; aw_hi = 0;
      beat_idx = 0; beats_seen = 0; wlast_cnt = 0; k_cmd++;
    end
    p_awv = bus_if.awvalid; p_awr = bus_if.awready;
    p_awaddr = bus_if.awaddr; p_awlen = bus_if.awlen; p_awid = bus_if.awid;
    p_wv = bus_if.wvalid; p_wr = bus_if.wready; p_wdata = bus_if.wdata;
  endtask

  // Command source, payload source and AXI slave, driven on the falling edge
  initial begin : bus
    cmd_valid = 0; cmd_hdr = '0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
    pld_valid = 0; pld_data = '0;
    bus_if.awready = 0; bus_if.wready = 0; bus_if.bvalid = 0; bus_if.bid = '0; bus_if.bresp = '0;
    cur = mk(128'd0, '0, 8'd0, '0, 0, 0, 0, 1, '0, 2'b00);
    k_cmd = 0;
    clear_model();
    forever begin
      @(negedge clk);
      cyc++;
      cmd_valid = (cmd_q.size() > 0) && !in_flight;
      if (cmd_valid) begin
        cmd_hdr = cmd_q[0].hdr; cmd_addr = cmd_q[0].addr;
        cmd_len = cmd_q[0].len; cmd_id = cmd_q[0].id;
      end
      bus_if.awready = (aw_cnt >= cur.aw_stall);
      bus_if.wready  = cur.w_toggle ? ((cyc % 2) == 1) : 1'b1;
      pld_valid = (pld_q.size() > 0) && !(cur.gap && (cyc % 3) == 0);
      pld_data  = pld_valid ? pld_q[0] : '0;
      bus_if.bvalid = b_armed && ((cyc - t_last) >= cur.bdel);
      bus_if.bid    = cur.bid;
      bus_if.bresp  = cur.bresp;
      #1;
      monitor();
    end
  end

  task automatic wait_done(int n);
    for (int i = 0; i < 600; i++) begin
      if (dut_done_cnt >= n) break;
      @(negedge clk);
    end
    chk("done_wait", dut_done_cnt >= n, 1);
    @(negedge clk);
  endtask

  initial begin : stim
    int nd;
    repeat (3) @(negedge clk);
    #3 rst_n = 1;
    @(negedge clk);

    // basic 3-beat burst
    cmd_q.push_back(mk(HDR1, 64'h0, 8'd2, 7'd3, 0, 0, 0, 1, 7'd3, 2'b00));
    wait_done(1);
    chk("t1_beats", beats_seen, 3);
    chk("t1_wlast_cnt", wlast_cnt, 1);
    chk("t1_hdr", w0_lo, 128'hC820_0000_1122_3344_5566_7788_0000_0020);
    chk("t1_delay", done_delay, 2);
    chk("t1_result", {done_resp, done_err}, 4'b0000);

    // AWREADY low for 3 cycles
    cmd_q.push_back(mk(128'h1111_2222_3333_4444_5555_6666_7777_8888, 64'h1000, 8'd1, 7'd4,
                       3, 0, 0, 2, 7'd4, 2'b00));
    wait_done(2);
    chk("t2_aw_hi", aw_hi, 4);

    // WREADY toggling with payload gaps
    cmd_q.push_back(mk(128'hA5A5_0000_0000_0000_0000_0000_0000_0003, 64'hDEAD_0000, 8'd3, 7'd9,
                       0, 1, 1, 3, 7'd9, 2'b00));
    wait_done(3);
    chk("t3_beats", beats_seen, 4);

    // BID mismatch with OKAY-exclusive response
    cmd_q.push_back(mk(HDR1, 64'h40, 8'd0, 7'd3, 0, 0, 0, 1, 7'd5, 2'b01));
    wait_done(4);
    chk("t4_resp", done_resp, 2'd1);
    chk("t4_err", done_err, 2'b10);

    // no BVALID at all: timeout
    cmd_q.push_back(mk(HDR1, 64'h80, 8'd1, 7'd6, 0, 0, 0, 9999, 7'd6, 2'b00));
    wait_done(5);
    chk("t5_delay", done_delay, 17);
    chk("t5_result", {done_resp, done_err}, {2'b10, 2'b01});

    // BVALID on the expiry cycle completes normally
    cmd_q.push_back(mk(HDR1, 64'hC0, 8'd1, 7'd6, 0, 0, 0, 16, 7'd6, 2'b00));
    wait_done(6);
    chk("t6_delay", done_delay, 17);
    chk("t6_result", {done_resp, done_err}, 4'b0000);

    // reset in the middle of a 4-beat burst
    nd = dut_done_cnt;
    cmd_q.push_back(mk(HDR1, 64'h100, 8'd3, 7'd1, 0, 1, 1, 1, 7'd1, 2'b00));
    for (int i = 0; i < 200; i++) begin
      if (beats_seen >= 1 && in_flight) break;
      @(negedge clk);
    end
    chk("t7_reached_data", beats_seen >= 1, 1);
    #3 rst_n = 0;
    #1 chk("t7_async_zero", {bus_if.awvalid, bus_if.wvalid, bus_if.bready, cmd_ready, pld_ready,
                              busy, done}, 0);
    repeat (3) @(negedge clk);
    #3 rst_n = 1;
    repeat (30) @(negedge clk);
    chk("t7_no_done", dut_done_cnt, nd);

    // single-beat burst after the reset
    cmd_q.push_back(mk(128'h0BAD_F00D_0000_0000_0000_0000_0000_0001, 64'h200, 8'd0, 7'd2,
                       0, 0, 0, 2, 7'd2, 2'b00));
    wait_done(nd + 1);
    chk("t8_beats", beats_seen, 1);
    chk("t8_wlast_cnt", wlast_cnt, 1);
    chk("t8_result", {done_resp, done_err}, 4'b0000);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
